// File: rtl/lu_arbiter_pkg.sv
// lu_pkg: shared constants and types for the lu_arbiter block.
//   - OP_* : logic-unit operation codes carried on OP_BUS
//   - state_t : sequencer states (IDLE, EXEC, DONE)
//   - LU_W : logic-unit data width
package lu_pkg;

  localparam int LU_W = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lu_gates.sv
// 8-bit gate blocks used by the shared logic unit.
//   AND8/OR8/XOR8 : a_i, b_i (8b) -> y_o (8b)
//   NOT8          : a_i (8b)      -> y_o (8b)
module AND8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module OR8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

module XOR8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

module NOT8 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = ~a_i;
endmodule

// File: rtl/lu_rr_pick.sv
// lu_rr_pick: combinational round-robin picker.
//   req_i  : per-requester valid
//   ptr_i  : requester with highest priority this round
//   pick_o : one-hot winner (zero when no request)
//   idx_o  : binary index of the winner
//   any_o  : at least one request present
module lu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the requester closest to the
  // pointer (searching upward with wrap) is the final assignment.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (req_i[cand]) begin
        pick_o       = '0;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lu_arbiter.sv
// lu_arbiter: round-robin arbiter/sequencer sharing one 8-bit logic unit
// (AND/OR/XOR/NOT) between N_REQ requesters. One operation in flight:
// IDLE (grant + capture) -> EXEC (compute) -> DONE (hold until taken).
//   CLK, RST (async, active-high)
//   REQ, OP_BUS, A_BUS, B_BUS : requester side, held until GNT seen
//   GNT        : one-hot acceptance strobe (combinational)
//   RES, RES_ID, RES_VALID, RES_READY : tagged result handshake
// Optional build macro LU_ARB_STATS_EN adds GNT_CNT (8-bit saturating
// grant counter per requester).
module lu_arbiter
  import lu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [2*N_REQ-1:0]   OP_BUS,
  input  logic [8*N_REQ-1:0]   A_BUS,
  input  logic [8*N_REQ-1:0]   B_BUS,
  output logic [N_REQ-1:0]     GNT,
  output logic [LU_W-1:0]      RES,
  output logic [IDW-1:0]       RES_ID,
  output logic                 RES_VALID,
  input  logic                 RES_READY
`ifdef LU_ARB_STATS_EN
  ,
  output logic [8*N_REQ-1:0]   GNT_CNT
`endif
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [1:0]      op_q;
  logic [LU_W-1:0] a_q, b_q;
  logic [IDW-1:0]  wid_q;
  logic [LU_W-1:0] res_q;
  logic [IDW-1:0]  res_id_q;
  logic            res_valid_q;

  logic [N_REQ-1:0] pick;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             launch, retire;

  logic [1:0]      sel_op;
  logic [LU_W-1:0] sel_a, sel_b;
  logic [LU_W-1:0] and_y, or_y, xor_y, not_y, unit_y;

  lu_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req_i  (REQ),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Operand select driven directly by the one-hot pick.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        sel_op = OP_BUS[2*i +: 2];
        sel_a  = A_BUS[8*i +: 8];
        sel_b  = B_BUS[8*i +: 8];
      end
    end
  end

  // FSM next-state and grant. GNT is also gated by RST so that no strobe
  // appears while reset is held (state is already IDLE then).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    GNT     = '0;
    launch  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any && !RST) begin
          GNT     = pick;
          launch  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_valid_q && RES_READY) begin
          retire  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = (wid_q == IDW'(N_REQ - 1)) ? '0 : wid_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wid_q       <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (launch) begin
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        wid_q <= pick_idx;
      end
      if (state_q == S_EXEC) begin
        res_q       <= unit_y;
        res_id_q    <= wid_q;
        res_valid_q <= 1'b1;
      end
      if (retire) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  AND8 u_and (.a_i(a_q), .b_i(b_q), .y_o(and_y));
  OR8  u_or  (.a_i(a_q), .b_i(b_q), .y_o(or_y));
  XOR8 u_xor (.a_i(a_q), .b_i(b_q), .y_o(xor_y));
  NOT8 u_not (.a_i(a_q), .y_o(not_y));

  always_comb begin
    unit_y = and_y;
    case (op_q)
      OP_AND:  unit_y = and_y;
      OP_OR:   unit_y = or_y;
      OP_XOR:  unit_y = xor_y;
      OP_NOT:  unit_y = not_y;
      default: unit_y = and_y;
    endcase
  end

  assign RES       = res_q;
  assign RES_ID    = res_id_q;
  assign RES_VALID = res_valid_q;

`ifdef LU_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [7:0] cnt_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          cnt_q <= '0;
        end else if (GNT[gi] && cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      assign GNT_CNT[8*gi +: 8] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_lu_arbiter.sv
module tb_lu_arbiter;

  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [N_REQ-1:0]     REQ;
  logic [2*N_REQ-1:0]   OP_BUS;
  logic [8*N_REQ-1:0]   A_BUS;
  logic [8*N_REQ-1:0]   B_BUS;
  logic [N_REQ-1:0]     GNT;
  logic [7:0]           RES;
  logic [IDW-1:0]       RES_ID;
  logic                 RES_VALID;
  logic                 RES_READY;
`ifdef LU_ARB_STATS_EN
  logic [8*N_REQ-1:0]   GNT_CNT;
`endif

  lu_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .OP_BUS    (OP_BUS),
    .A_BUS     (A_BUS),
    .B_BUS     (B_BUS),
    .GNT       (GNT),
    .RES       (RES),
    .RES_ID    (RES_ID),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY)
`ifdef LU_ARB_STATS_EN
    ,
    .GNT_CNT   (GNT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [7:0] res;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         model_ptr = 0;
  bit         busy = 0;
  bit         prev_valid = 0;
  bit         rr_chk = 0;
  int         grant_cyc = 0;
  int         last_grant_cyc = -1;
  int         hs_cnt = 0;
  logic [7:0] last_res, held_res;
  int         last_id, held_id;
  logic [N_REQ-1:0] gnt_seen = '0;
  int         gcnt [N_REQ];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of the logic unit.
  function automatic logic [7:0] ref_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge CLK) begin
    int         exp_w;
    int         j;
    logic [N_REQ-1:0] exp_g;
    exp_t       e;
    cyc++;
    if (RST) begin
      chk("rst_gnt", GNT, 0);
      chk("rst_valid", RES_VALID, 0);
      busy = 0;
      sb.delete();
      model_ptr = 0;
      prev_valid = 0;
      gnt_seen = '0;
      last_grant_cyc = -1;
      for (int i = 0; i < N_REQ; i++) gcnt[i] = 0;
    end else begin
      if (!rr_chk) last_grant_cyc = -1;
      exp_w = -1;
      if (!busy) begin
        for (int k = 0; k < N_REQ; k++) begin
          j = (model_ptr + k) % N_REQ;
          if (REQ[j]) begin
            exp_w = j;
            break;
          end
        end
      end
      exp_g = '0;
      if (exp_w >= 0) exp_g[exp_w] = 1'b1;
      chk("gnt", GNT, exp_g);
      gnt_seen = GNT;
      if (exp_w >= 0) begin
        e.id  = exp_w;
        e.res = ref_op(OP_BUS[2*exp_w +: 2], A_BUS[8*exp_w +: 8], B_BUS[8*exp_w +: 8]);
        sb.push_back(e);
        busy = 1;
        model_ptr = (exp_w + 1) % N_REQ;
        grant_cyc = cyc;
        grant_log.push_back(exp_w);
        if (gcnt[exp_w] < 255) gcnt[exp_w]++;
        if (rr_chk && last_grant_cyc >= 0) chk("rr_spacing", cyc - last_grant_cyc, 3);
        last_grant_cyc = cyc;
        $display("grant  req=%0d op=%0d a=%02h b=%02h exp_res=%02h", exp_w,
                 OP_BUS[2*exp_w +: 2], A_BUS[8*exp_w +: 8], B_BUS[8*exp_w +: 8], e.res);
      end
      if (RES_VALID) begin
        if (!prev_valid) begin
          chk("latency", cyc - grant_cyc, 2);
          if (sb.size() == 0) begin
            chk("unexpected_res", 1, 0);
          end else begin
            chk("res", RES, sb[0].res);
            chk("res_id", RES_ID, sb[0].id);
          end
        end else begin
          chk("stall_res", RES, held_res);
          chk("stall_id", RES_ID, held_id);
        end
        held_res = RES;
        held_id  = RES_ID;
        if (RES_READY) begin
          if (sb.size() > 0) void'(sb.pop_front());
          busy = 0;
          hs_cnt++;
          last_res = RES;
          last_id  = RES_ID;
          $display("result id=%0d res=%02h", RES_ID, RES);
        end
        prev_valid = !RES_READY;
      end else begin
        prev_valid = 0;
      end
    end
  end

  task automatic do_op(int i, logic [1:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] exp);
    int h0;
    bit ok;
    @(posedge CLK);
    #1;
    OP_BUS[2*i +: 2] = op;
    A_BUS[8*i +: 8]  = a;
    B_BUS[8*i +: 8]  = b;
    REQ = '0;
    REQ[i] = 1'b1;
    RES_READY = 1'b1;
    h0 = hs_cnt;
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge CLK);
      if (gnt_seen[i]) begin
        ok = 1;
        break;
      end
    end
    #1 REQ[i] = 1'b0;
    chk("dir_grant", 32'(ok), 1);
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge CLK);
      if (hs_cnt > h0) begin
        ok = 1;
        break;
      end
    end
    chk("dir_done", 32'(ok), 1);
    if (ok) begin
      chk("dir_res", last_res, exp);
      chk("dir_id", last_id, i);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(posedge CLK);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("drain", 32'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  g0;
    bit  ok;
    int  rr_exp [5];
    RST = 1'b1;
    REQ = '0;
    OP_BUS = '0;
    A_BUS = '0;
    B_BUS = '0;
    RES_READY = 1'b1;
    #3;
    chk("reset_res", RES, 0);
    chk("reset_res_id", RES_ID, 0);
    chk("reset_valid", RES_VALID, 0);
    chk("reset_gnt", GNT, 0);
    repeat (3) @(posedge CLK);
    #3 RST = 1'b0;

    // Single op and all ops on requester 2.
    do_op(0, 2'b00, 8'hF0, 8'h3C, 8'h30);
    do_op(2, 2'b00, 8'hA5, 8'h0F, 8'h05);
    do_op(2, 2'b01, 8'hA5, 8'h0F, 8'hAF);
    do_op(2, 2'b10, 8'hA5, 8'h0F, 8'hAA);
    do_op(2, 2'b11, 8'hA5, 8'h0F, 8'h5A);

    // Reset while a result is held in DONE.
    @(posedge CLK);
    #1;
    OP_BUS[1:0] = 2'b10;
    A_BUS[7:0]  = 8'h55;
    B_BUS[7:0]  = 8'hFF;
    REQ = 4'b0001;
    RES_READY = 1'b0;
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge CLK);
      #2;
      if (RES_VALID) begin
        ok = 1;
        break;
      end
    end
    chk("rstmid_reach_done", 32'(ok), 1);
    REQ = 4'b1111;
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("rstmid_valid", RES_VALID, 0);
    chk("rstmid_gnt", GNT, 0);
    chk("rstmid_res", RES, 0);
    chk("rstmid_res_id", RES_ID, 0);

    // Round-robin with all requests held, starting from pointer 0.
    rr_chk = 1;
    RES_READY = 1'b1;
    g0 = grant_log.size();
    @(negedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge CLK);
      if (grant_log.size() >= g0 + 5) begin
        ok = 1;
        break;
      end
    end
    #1 REQ = '0;
    rr_chk = 0;
    chk("rr_reached", 32'(ok), 1);
    rr_exp = '{0, 1, 2, 3, 0};
    if (ok) begin
      for (int k = 0; k < 5; k++) chk("rr_order", grant_log[g0 + k], rr_exp[k]);
    end
    drain();

    // Backpressure: long stall in DONE with all requests pending.
    @(posedge CLK);
    #1;
    REQ = 4'b1111;
    RES_READY = 1'b0;
    g0 = grant_log.size();
    repeat (13) @(posedge CLK);
    chk("bp_single_grant", grant_log.size(), g0 + 1);
    #1 RES_READY = 1'b1;
    @(posedge CLK);
    #1 RES_READY = 1'b0;
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge CLK);
      if (grant_log.size() > g0 + 1) begin
        ok = 1;
        break;
      end
    end
    #1;
    REQ = '0;
    RES_READY = 1'b1;
    chk("bp_regrant", 32'(ok), 1);
    if (ok) begin
      chk("bp_first_w", grant_log[g0], 1);
      chk("bp_next_w", grant_log[g0 + 1], 2);
    end
    drain();

    // Randomized traffic with random backpressure and request withdrawal.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_seen[i]) begin
          REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(0, 2) == 0) begin
          OP_BUS[2*i +: 2] = 2'($urandom_range(0, 3));
          A_BUS[8*i +: 8]  = 8'($urandom_range(0, 255));
          B_BUS[8*i +: 8]  = 8'($urandom_range(0, 255));
          REQ[i] = 1'b1;
        end else if (REQ[i] && $urandom_range(0, 19) == 0) begin
          REQ[i] = 1'b0;
        end
      end
      RES_READY = ($urandom_range(0, 3) != 0);
    end
    REQ = '0;
    RES_READY = 1'b1;
    drain();
    chk("sb_empty", sb.size(), 0);

`ifdef LU_ARB_STATS_EN
    // Requester 1 alone for well over 255 grants.
    @(posedge CLK);
    #1;
    REQ = 4'b0010;
    repeat (930) @(posedge CLK);
    #1 REQ = '0;
    drain();
    chk("stats_sat_r1", GNT_CNT[15:8], 8'd255);
    for (int i = 0; i < N_REQ; i++) chk("stats_slice", GNT_CNT[8*i +: 8], gcnt[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lu_arbiter.md
Name: lu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit bitwise logic unit between N_REQ requesters.
- The logic unit supports AND, OR, XOR and NOT, and is built from the existing 8-bit gate blocks AND8, OR8, XOR8 and NOT8.
- The block accepts one operation at a time, registers the operands, executes, and holds a tagged result until the consumer takes it.
- It sits between the requester blocks and the shared logic datapath.

Parameters:
- N_REQ, 4, number of requesters (legal range 2..8).
- IDW, 2, requester-ID width; must equal ceil(log2(N_REQ)).

Ports:
- CLK  input  1  the single clock of the block; rising edge.
- RST  input  1  asynchronous reset, active-high.
- REQ  input  N_REQ  per-requester valid; requester i holds REQ[i], OP and operands stable until GNT[i] is seen.
- OP_BUS  input  2*N_REQ  slice i = [2i+1:2i]. Encoding: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- A_BUS  input  8*N_REQ  operand A of requester i, slice [8i+7:8i].
- B_BUS  input  8*N_REQ  operand B of requester i; ignored for NOT.
- GNT  output  N_REQ  one-hot acceptance strobe; combinational from state and REQ; at most one bit high.
- RES  output  8  registered result.
- RES_ID  output  IDW  index of the requester that owns RES.
- RES_VALID  output  1  result valid.
- RES_READY  input  1  consumer ready.

Behaviour:
- Reset values: the asynchronous reset is active-high. While RST=1 the block is held in reset; at reset:
  - state=IDLE.
  - RES=0, RES_ID=0, RES_VALID=0, GNT=0.
  - rr pointer=0.
  - operand and op registers = 0.
- Reset mid-operation: any in-flight or held transaction is discarded with no GNT or RES_VALID glitch.
- State machine, 2-bit encoding: IDLE=00, EXEC=01, DONE=10.
- IDLE:
  - If REQ != 0, winner w = first set REQ bit searching upward from the pointer, wrapping modulo N_REQ.
  - GNT[w]=1 for this cycle only.
  - On the edge: capture OP, A and B of w, record w; go to EXEC.
  - If REQ == 0: GNT=0 and the state stays IDLE.
- EXEC:
  - The captured operands drive the gate datapath.
  - On the edge: RES <= unit output, RES_ID <= w, RES_VALID <= 1; go to DONE.
  - GNT=0.
- DONE:
  - RES, RES_ID and RES_VALID are held stable while RES_READY=0 (stall of any length).
  - On an edge with RES_VALID & RES_READY: RES_VALID <= 0, pointer <= (w+1) mod N_REQ, go to IDLE.
  - GNT=0. RES is not cleared.
- Latency: grant edge to RES_VALID high is 2 edges.
- Minimum issue interval is 3 cycles: IDLE, EXEC, DONE with RES_READY=1.
- No new grant is issued while DONE; requests wait.
- Fairness: a continuously requesting requester is granted within N_REQ transactions.
- REQ deasserted by a requester before its grant: it is simply not selected; no error.
- Unused OP code: none, all four codes are legal. NOT output = ~A; B is ignored.
- Pointer wrap: after w = N_REQ-1 the pointer becomes 0.

Optional Feature:
- Macro: LU_ARB_STATS_EN.
- Defined:
  - Adds output GNT_CNT, width 8*N_REQ.
  - Slice i holds a per-requester grant counter: +1 on each edge where GNT[i]=1, saturating at 255.
  - Cleared by RST.
- Undefined: the GNT_CNT port and its counters are absent; all other behaviour is identical.

Decomposition:
- Package lu_pkg:
  - OP codes OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11.
  - State encodings S_IDLE, S_EXEC, S_DONE.
  - Result width constant LU_W=8.
- Sub-module lu_rr_pick: combinational round-robin picker.
  - Inputs: REQ, pointer.
  - Outputs: one-hot pick, pick index, any-valid.
- The top level holds the FSM and registers, and instantiates AND8, OR8, XOR8 and NOT8 with an OP-selected 4:1 mux.

Test Plan:
- Reset mid-DONE: assert RST while RES_VALID=1 -> RES_VALID, GNT and RES go to 0 immediately (asynchronous reset); after release, the next REQ[0] is granted first.
- Single op: REQ=0001, OP=00, A=8'hF0, B=8'h3C -> GNT=0001 for 1 cycle; 2 edges later RES=8'h30, RES_ID=0, RES_VALID=1.
- All ops on requester 2, A=8'hA5, B=8'h0F:
  - AND -> 8'h05.
  - OR -> 8'hAF.
  - XOR -> 8'hAA.
  - NOT -> 8'h5A (B ignored), RES_ID=2 each time.
- Round-robin: REQ=1111 held, RES_READY=1 -> grant order 0,1,2,3,0; grants spaced exactly 3 cycles apart.
- Backpressure: RES_READY=0 for 10 cycles in DONE -> RES and RES_ID stable, GNT=0 despite REQ=1111; ready for 1 cycle -> return to IDLE, next grant goes to w+1.
- With LU_ARB_STATS_EN: requester 1 granted 300 times -> GNT_CNT[15:8]=255 (saturated), other slices unaffected.
